// File: rtl/qs_bank_sched.sv
// qs_bank_sched
//   Bank scheduler for the quicksort engine. Tracks the lifecycle state of
//   every sort bank and hands banks, in strict ring order, to the enqueue,
//   sort and dequeue stages. Each stage holds at most one bank at a time and
//   the bank advances one lifecycle step when the stage reports completion,
//   so packets leave the engine in arrival order.
//
// Ports
//   clk                     rising-edge clock
//   rst                     asynchronous, active-low reset
//   enq_req / enq_done      enqueue stage request (level) and completion pulse
//   enq_gnt_r / enq_idx_r   one-cycle grant pulse and granted bank index
//   srt_*                   same set for the sort stage
//   deq_*                   same set for the dequeue stage
//   occ_r                   number of banks that are not EMPTY (0..N_BANKS)
//   err_r                   sticky flag: a done arrived while its stage was idle

module qs_bank_sched #(
  parameter int N_BANKS = 4,
  localparam int BW = $clog2(N_BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_req,
  input  logic          enq_done,
  output logic          enq_gnt_r,
  output logic [BW-1:0] enq_idx_r,
  input  logic          srt_req,
  input  logic          srt_done,
  output logic          srt_gnt_r,
  output logic [BW-1:0] srt_idx_r,
  input  logic          deq_req,
  input  logic          deq_done,
  output logic          deq_gnt_r,
  output logic [BW-1:0] deq_idx_r,
  output logic [BW:0]   occ_r,
  output logic          err_r
);

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    FILLING  = 3'd1,
    FULL     = 3'd2,
    SORTING  = 3'd3,
    SORTED   = 3'd4,
    DRAINING = 3'd5
  } bank_state_t;

  // Stage numbering used by every per-stage vector: 0 enqueue, 1 sort, 2 dequeue.
  localparam int NS = 3;

  bank_state_t           bank_q [N_BANKS];
  bank_state_t           bank_d [N_BANKS];
  logic [NS-1:0][BW-1:0] ptr_q, ptr_d;
  logic [NS-1:0][BW-1:0] idx_q, idx_d;
  logic [NS-1:0]         busy_q, busy_d;
  logic [NS-1:0]         gnt_q, gnt_d;
  logic [BW:0]           occ_q, occ_d;
  logic                  err_q, err_d;
  logic [NS-1:0]         req, done;
  logic                  occ_inc, occ_dec;

  assign req  = {deq_req, srt_req, enq_req};
  assign done = {deq_done, srt_done, enq_done};

  // State a bank must be in before stage s may take it.
  function automatic bank_state_t avail_state(input int s);
    case (s)
      0:       return EMPTY;
      1:       return FULL;
      default: return SORTED;
    endcase
  endfunction

  // State a bank enters when stage s is granted it.
  function automatic bank_state_t grant_state(input int s);
    case (s)
      0:       return FILLING;
      1:       return SORTING;
      default: return DRAINING;
    endcase
  endfunction

  // State a bank enters when stage s reports completion on it.
  function automatic bank_state_t done_state(input int s);
    case (s)
      0:       return FULL;
      1:       return SORTED;
      default: return EMPTY;
    endcase
  endfunction

  // All three stages are evaluated side by side. Grant and valid done are
  // mutually exclusive within a stage (grant needs !busy, done needs busy),
  // and different stages always touch banks in different states, so the
  // bank_d writes below never collide. A done in the same cycle as a req
  // frees the stage only for the following cycle because the grant test
  // looks at busy_q, not busy_d.
  always_comb begin
    bank_d  = bank_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    gnt_d   = '0;
    err_d   = err_q;
    occ_inc = 1'b0;
    occ_dec = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (done[s]) begin
        if (busy_q[s]) begin
          bank_d[idx_q[s]] = done_state(s);
          ptr_d[s]         = ptr_q[s] + BW'(1);
          busy_d[s]        = 1'b0;
          if (s == 2) occ_dec = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      if (req[s] && !busy_q[s] && (bank_q[ptr_q[s]] == avail_state(s))) begin
        gnt_d[s]         = 1'b1;
        busy_d[s]        = 1'b1;
        idx_d[s]         = ptr_q[s];
        bank_d[ptr_q[s]] = grant_state(s);
        if (s == 0) occ_inc = 1'b1;
      end
    end
    occ_d = occ_q + {{BW{1'b0}}, occ_inc} - {{BW{1'b0}}, occ_dec};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BANKS; i++) bank_q[i] <= EMPTY;
      ptr_q  <= '0;
      idx_q  <= '0;
      busy_q <= '0;
      gnt_q  <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_BANKS; i++) bank_q[i] <= bank_d[i];
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      gnt_q  <= gnt_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  assign enq_gnt_r = gnt_q[0];
  assign srt_gnt_r = gnt_q[1];
  assign deq_gnt_r = gnt_q[2];
  assign enq_idx_r = idx_q[0];
  assign srt_idx_r = idx_q[1];
  assign deq_idx_r = idx_q[2];
  assign occ_r     = occ_q;
  assign err_r     = err_q;

endmodule

// File: tb/tb_qs_bank_sched.sv
// tb_qs_bank_sched
//   Directed bench for qs_bank_sched with N_BANKS=4. A table of per-cycle
//   input patterns and hand-computed outputs walks a single bank through its
//   whole lifecycle, fills the ring, checks the full-ring hold-off, ordering,
//   simultaneous done events and wrap-around. Short hand-written sequences
//   then cover the protocol error flag and an asynchronous mid-run reset.
//
// Ports: none (top-level bench).

module tb_qs_bank_sched;

  localparam int N_BANKS = 4;
  localparam int BW = 2;

  logic          clk;
  logic          rst;
  logic          enq_req, enq_done, srt_req, srt_done, deq_req, deq_done;
  logic          enq_gnt_r, srt_gnt_r, deq_gnt_r;
  logic [BW-1:0] enq_idx_r, srt_idx_r, deq_idx_r;
  logic [BW:0]   occ_r;
  logic          err_r;

  int checks;
  int failures;

  // Inputs packed {enq_req, enq_done, srt_req, srt_done, deq_req, deq_done};
  // outputs packed {eg, ei[1:0], sg, si[1:0], dg, di[1:0], occ[2:0], err}.
  typedef struct {
    logic [5:0]  stim;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs [32];

  qs_bank_sched #(.N_BANKS(N_BANKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_req   (enq_req),
    .enq_done  (enq_done),
    .enq_gnt_r (enq_gnt_r),
    .enq_idx_r (enq_idx_r),
    .srt_req   (srt_req),
    .srt_done  (srt_done),
    .srt_gnt_r (srt_gnt_r),
    .srt_idx_r (srt_idx_r),
    .deq_req   (deq_req),
    .deq_done  (deq_done),
    .deq_gnt_r (deq_gnt_r),
    .deq_idx_r (deq_idx_r),
    .occ_r     (occ_r),
    .err_r     (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic eg, input logic [1:0] ei,
                                     input logic sg, input logic [1:0] si,
                                     input logic dg, input logic [1:0] di,
                                     input logic [2:0] occ, input logic err);
    return {eg, ei, sg, si, dg, di, occ, err};
  endfunction

  function automatic logic [12:0] observed();
    return {enq_gnt_r, enq_idx_r, srt_gnt_r, srt_idx_r,
            deq_gnt_r, deq_idx_r, occ_r, err_r};
  endfunction

  // Drives one cycle of inputs from a negedge and returns on the next
  // negedge, so outputs are sampled half a period after the active edge.
  task automatic apply_stimulus(input logic [5:0] stim);
    {enq_req, enq_done, srt_req, srt_done, deq_req, deq_done} = stim;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got eg=%b ei=%0d sg=%b si=%0d dg=%b di=%0d occ=%0d err=%b, expected eg=%b ei=%0d sg=%b si=%0d dg=%b di=%0d occ=%0d err=%b",
               name, act[12], act[11:10], act[9], act[8:7], act[6], act[5:4], act[3:1], act[0],
               exp[12], exp[11:10], exp[9], exp[8:7], exp[6], exp[5:4], exp[3:1], exp[0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    {enq_req, enq_done, srt_req, srt_done, deq_req, deq_done} = '0;

    // Single bank lifecycle through bank 0.
    vecs[0]  = '{6'b000000, mk(0,0, 0,0, 0,0, 0, 0)};
    vecs[1]  = '{6'b100000, mk(1,0, 0,0, 0,0, 1, 0)};
    vecs[2]  = '{6'b000000, mk(0,0, 0,0, 0,0, 1, 0)};
    vecs[3]  = '{6'b010000, mk(0,0, 0,0, 0,0, 1, 0)};
    vecs[4]  = '{6'b001000, mk(0,0, 1,0, 0,0, 1, 0)};
    vecs[5]  = '{6'b001000, mk(0,0, 0,0, 0,0, 1, 0)};
    vecs[6]  = '{6'b000100, mk(0,0, 0,0, 0,0, 1, 0)};
    vecs[7]  = '{6'b000010, mk(0,0, 0,0, 1,0, 1, 0)};
    vecs[8]  = '{6'b000001, mk(0,0, 0,0, 0,0, 0, 0)};
    // Ring fill 1,2,3,0 with req held across each done.
    vecs[9]  = '{6'b100000, mk(1,1, 0,0, 0,0, 1, 0)};
    vecs[10] = '{6'b110000, mk(0,1, 0,0, 0,0, 1, 0)};
    vecs[11] = '{6'b100000, mk(1,2, 0,0, 0,0, 2, 0)};
    vecs[12] = '{6'b110000, mk(0,2, 0,0, 0,0, 2, 0)};
    vecs[13] = '{6'b100000, mk(1,3, 0,0, 0,0, 3, 0)};
    vecs[14] = '{6'b110000, mk(0,3, 0,0, 0,0, 3, 0)};
    vecs[15] = '{6'b100000, mk(1,0, 0,0, 0,0, 4, 0)};
    vecs[16] = '{6'b110000, mk(0,0, 0,0, 0,0, 4, 0)};
    // Full ring: enq_req held off, no error.
    vecs[17] = '{6'b100000, mk(0,0, 0,0, 0,0, 4, 0)};
    vecs[18] = '{6'b100000, mk(0,0, 0,0, 0,0, 4, 0)};
    // Ordering: deq_req waits until bank 1 is SORTED, then gets idx 1.
    vecs[19] = '{6'b001010, mk(0,0, 1,1, 0,0, 4, 0)};
    vecs[20] = '{6'b000110, mk(0,0, 0,1, 0,0, 4, 0)};
    vecs[21] = '{6'b001010, mk(0,0, 1,2, 1,1, 4, 0)};
    vecs[22] = '{6'b000100, mk(0,0, 0,2, 0,1, 4, 0)};
    vecs[23] = '{6'b000001, mk(0,0, 0,2, 0,1, 3, 0)};
    // Wrap-around enqueue onto freed bank 1, then simultaneous dones.
    vecs[24] = '{6'b100000, mk(1,1, 0,2, 0,1, 4, 0)};
    vecs[25] = '{6'b000010, mk(0,1, 0,2, 1,2, 4, 0)};
    vecs[26] = '{6'b010001, mk(0,1, 0,2, 0,2, 3, 0)};
    // Enqueue grant and deq_done together leave occupancy unchanged.
    vecs[27] = '{6'b001000, mk(0,1, 1,3, 0,2, 3, 0)};
    vecs[28] = '{6'b000100, mk(0,1, 0,3, 0,2, 3, 0)};
    vecs[29] = '{6'b000010, mk(0,1, 0,3, 1,3, 3, 0)};
    vecs[30] = '{6'b100001, mk(1,2, 0,3, 0,3, 3, 0)};
    vecs[31] = '{6'b010000, mk(0,2, 0,3, 0,3, 3, 0)};

    #2;
    check_output("reset_values", mk(0,0, 0,0, 0,0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      apply_stimulus(vecs[i].stim);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Protocol error: srt_done with the sort stage idle sets err_r and must
    // not move srt_ptr, so the next sort grant is still bank 0.
    apply_stimulus(6'b000100);
    check_output("err_stray_done", mk(0,2, 0,3, 0,3, 3, 1));
    apply_stimulus(6'b001000);
    check_output("err_no_state_change", mk(0,2, 1,0, 0,3, 3, 1));
    apply_stimulus(6'b000100);
    check_output("err_sticky", mk(0,2, 0,0, 0,3, 3, 1));

    // Two stages in flight (bank 3 FILLING, bank 1 SORTING), then reset
    // asserted away from any clock edge.
    apply_stimulus(6'b101000);
    check_output("pre_reset_grants", mk(1,3, 1,1, 0,3, 4, 1));
    {enq_req, enq_done, srt_req, srt_done, deq_req, deq_done} = '0;
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset", mk(0,0, 0,0, 0,0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(6'b100000);
    check_output("post_reset_enq", mk(1,0, 0,0, 0,0, 1, 0));
    // Nothing FULL or SORTED yet: sort and dequeue are held off.
    apply_stimulus(6'b001010);
    check_output("empty_ring_holdoff", mk(0,0, 0,0, 0,0, 1, 0));
    apply_stimulus(6'b001010);
    check_output("empty_ring_holdoff2", mk(0,0, 0,0, 0,0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
